// File: rtl/dmem_access_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl_pkg
// Shared definitions for the MEM-stage data memory sequencer.
//   state_e     : sequencer state encoding (IDLE/REQ/DONE/ERR)
//   OPC_*       : RV32I major opcodes as seen by the main control decoder;
//                 only lw asserts MemRead and only sw asserts MemWrite
//   is_load/is_store : decoder view of an opcode
// ----------------------------------------------------------------------------
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ADDI  = 7'b0010011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;

    function automatic logic is_load(input logic [6:0] opc);
        return opc == OPC_LW;
    endfunction

    function automatic logic is_store(input logic [6:0] opc);
        return opc == OPC_SW;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Request/acknowledge bus between the sequencer and the data memory.
//   mem_req_o   : request, held for the whole transaction
//   mem_we_o    : 1 = write, 0 = read
//   mem_addr_o  : latched address
//   mem_wdata_o : latched store data
//   mem_ack_i   : one-cycle completion from memory
//   mem_rdata_i : read data, valid with mem_ack_i
// Signal suffixes are from the sequencer's point of view.
// Modports: master = sequencer, slave = memory.
// ----------------------------------------------------------------------------
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/dmem_access_ctrl_wait_counter.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl_wait_counter
// 8-bit watchdog counter for the REQ state.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : clear to zero (takes priority over en_i)
//   en_i         : count this cycle
//   tc_o         : this enabled cycle is the MAX_WAIT-th counted cycle
// ----------------------------------------------------------------------------
module dmem_access_ctrl_wait_counter #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 8'd0;
        else if (en_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q holds the number of cycles already spent, so the current cycle
    // is number MAX_WAIT when cnt_q reaches MAX_WAIT-1.
    assign tc_o = en_i && (cnt_q == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage sequencer for a variable-latency data memory. Launches one
// transaction per lw/sw, stalls the pipeline until it completes, returns
// load data, and flags a hung memory with a sticky watchdog error.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   MemRead_i, MemWrite_i : MEM-stage instruction is lw / sw
//   addr_i, wdata_i       : effective address, store data
//   stall_o               : freeze front of pipeline, bubble MEM/WB
//   rdata_o, rdata_valid_o: load data and its one-cycle valid pulse
//   timeout_o             : sticky watchdog error
//   stall_cnt_o           : saturating count of stalled cycles
//   mem                   : memory bus (master side)
// ----------------------------------------------------------------------------
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              timeout_o,
    output logic [31:0]       stall_cnt_o,
    dmem_access_ctrl_if.master mem
);
    state_e            state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [31:0]       stall_cnt_q;
    logic              launch;
    logic              tc;

    assign launch = MemRead_i | MemWrite_i;

    // Counter is held clear outside REQ, so it starts from zero on entry.
    dmem_access_ctrl_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q != S_REQ),
        .en_i  (state_q == S_REQ),
        .tc_o  (tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (launch) state_d = S_REQ;
            // Ack is checked first so an ack on the last allowed cycle wins.
            S_REQ: begin
                if (mem.mem_ack_i)
                    state_d = S_DONE;
                else if (tc)
                    state_d = S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend on state only, except the same-cycle stall in IDLE.
    always_comb begin
        stall_o       = 1'b0;
        mem.mem_req_o = 1'b0;
        rdata_valid_o = 1'b0;
        timeout_o     = 1'b0;
        case (state_q)
            S_IDLE: stall_o = launch;
            S_REQ: begin
                stall_o       = 1'b1;
                mem.mem_req_o = 1'b1;
            end
            S_DONE:  rdata_valid_o = ~we_q;
            S_ERR: begin
                stall_o   = 1'b1;
                timeout_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == S_IDLE && launch) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                // Both strobes set is an illegal decode; treat it as a read.
                we_q    <= MemWrite_i & ~MemRead_i;
            end
            if (state_q == S_REQ && mem.mem_ack_i && !we_q)
                rdata_q <= mem.mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt_q <= 32'd0;
        else if (stall_o && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign rdata_o         = rdata_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int MAXW = 15;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall_o, rdata_valid_o, timeout_o;
    logic [31:0] rdata_o, stall_cnt_o;

    dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .MemRead_i     (MemRead),
        .MemWrite_i    (MemWrite),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .timeout_o     (timeout_o),
        .stall_cnt_o   (stall_cnt_o),
        .mem           (mif)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    req_t        req_q[$];
    logic [31:0] rd_q[$];
    int          ref_stall = 0;
    bit          mon_en = 0;
    logic        exp_stall = 0, exp_req = 0, exp_rv = 0, exp_to = 0;
    logic        prev_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle status expectations plus scoreboard pops on
    // each new request and each load-data pulse.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            chk("stall_o", stall_o, exp_stall);
            chk("mem_req_o", mif.mem_req_o, exp_req);
            chk("rdata_valid_o", rdata_valid_o, exp_rv);
            chk("timeout_o", timeout_o, exp_to);
            if (mif.mem_req_o && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("mem_we_o", mif.mem_we_o, r.we);
                    chk("mem_addr_o", mif.mem_addr_o, r.addr);
                    chk("mem_wdata_o", mif.mem_wdata_o, r.wdata);
                end
            end
            if (rdata_valid_o) begin
                if (rd_q.size() == 0) chk("unexpected_rvalid", 1, 0);
                else chk("rdata_o", rdata_o, rd_q.pop_front());
            end
            prev_req = mif.mem_req_o;
        end else begin
            prev_req = 1'b0;
        end
    end

    // One clock cycle: inputs applied at the falling edge with the
    // status the spec requires for that cycle.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic ack, input logic [31:0] rdat,
                       input logic xs, input logic xr, input logic xrv, input logic xto);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; addr = a; wdata = d;
        mif.mem_ack_i = ack; mif.mem_rdata_i = rdat;
        exp_stall = xs; exp_req = xr; exp_rv = xrv; exp_to = xto;
    endtask

    // One lw/sw taking lat REQ cycles (ack in the last one), then DONE.
    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input logic [31:0] rdat);
        req_t r;
        r.we = wr & ~rd; r.addr = a; r.wdata = d;
        req_q.push_back(r);
        if (rd) rd_q.push_back(rdat);
        ref_stall += lat + 1;
        cyc(rd, wr, a, d, 1'($urandom_range(0, 1)), $urandom, 1, 0, 0, 0);
        for (int k = 1; k <= lat; k++)
            cyc(rd, wr, a, d, k == lat, (k == lat) ? rdat : $urandom, 1, 1, 0, 0);
        // DONE: inputs still show the finished instruction; stray ack ignored
        cyc(rd, wr, a, d, 1'($urandom_range(0, 1)), $urandom, 0, 0, rd, 0);
    endtask

    task automatic nop_cycle();
        cyc(0, 0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 0, 0, 0, 0);
    endtask

    task automatic check_cnt(input string name);
        #3;
        chk(name, stall_cnt_o, ref_stall);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        mon_en = 0; rst = 1;
        MemRead = 0; MemWrite = 0; mif.mem_ack_i = 0;
        @(negedge clk);
        rst = 0;
        exp_stall = 0; exp_req = 0; exp_rv = 0; exp_to = 0;
        ref_stall = 0;
        mon_en = 1;
        #3;
        chk("rst_stall", stall_o, 0);
        chk("rst_rvalid", rdata_valid_o, 0);
        chk("rst_req", mif.mem_req_o, 0);
        chk("rst_we", mif.mem_we_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_addr", mif.mem_addr_o, 0);
        chk("rst_wdata", mif.mem_wdata_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
    endtask

    initial begin
        logic [6:0] ops [5];
        mif.mem_ack_i = 0;
        mif.mem_rdata_i = '0;
        ops[0] = OPC_RTYPE; ops[1] = OPC_ADDI; ops[2] = OPC_LW;
        ops[3] = OPC_SW;    ops[4] = OPC_BEQ;

        reset_dut();

        // lw 0x10, ack in 3rd REQ cycle: 4 stall cycles
        mem_op(1, 0, 32'h10, $urandom, 3, 32'hDEADBEEF);
        check_cnt("cnt_lw");
        // sw 0x20, immediate ack: 2 more stall cycles
        mem_op(0, 1, 32'h20, 32'h1234, 1, $urandom);
        check_cnt("cnt_sw");
        nop_cycle();

        // back-to-back lw then sw from a clean count
        reset_dut();
        mem_op(1, 0, 32'h40, 32'h5, 1, 32'hCAFEF00D);
        mem_op(0, 1, 32'h44, 32'h77, 1, $urandom);
        check_cnt("cnt_b2b");

        // illegal decode with both strobes is a read; ack on the last legal cycle
        mem_op(1, 1, 32'h80, 32'h99, MAXW, 32'hA5A5A5A5);
        check_cnt("cnt_both");

        // non-memory stream with stray acks
        for (int i = 0; i < 8; i++) nop_cycle();
        check_cnt("cnt_nops");

        // random instruction mix
        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 4)];
            if (is_load(op) || is_store(op))
                mem_op(is_load(op), is_store(op), $urandom, $urandom,
                       $urandom_range(1, MAXW), $urandom);
            else
                nop_cycle();
        end
        check_cnt("cnt_random");

        // reset during the 2nd REQ cycle, then a late ack
        begin
            req_t r;
            r.we = 0; r.addr = 32'h100; r.wdata = 32'h0;
            req_q.push_back(r);
            cyc(1, 0, 32'h100, 32'h0, 0, $urandom, 1, 0, 0, 0);
            cyc(1, 0, 32'h100, 32'h0, 0, $urandom, 1, 1, 0, 0);
            cyc(1, 0, 32'h100, 32'h0, 0, $urandom, 1, 1, 0, 0);
            rst = 1;
            cyc(0, 0, 32'h0, 32'h0, 1, 32'h13572468, 0, 0, 0, 0);
            rst = 0;
            ref_stall = 0;
            nop_cycle();
            #3;
            chk("abort_rdata", rdata_o, 0);
            chk("abort_cnt", stall_cnt_o, 0);
        end

        // no ack: ERR after MAX_WAIT REQ cycles, sticky until reset
        cyc(1, 0, 32'h200, 32'h0, 0, $urandom, 1, 0, 0, 0);
        begin
            req_t r;
            r.we = 0; r.addr = 32'h200; r.wdata = 32'h0;
            req_q.push_back(r);
        end
        for (int k = 0; k < MAXW; k++)
            cyc(1, 0, 32'h200, 32'h0, 0, $urandom, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++)
            cyc(0, 0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 1, 0, 0, 1);
        ref_stall = 1 + MAXW + 4;
        cyc(0, 0, 32'h0, 32'h0, 0, $urandom, 1, 0, 0, 1);
        check_cnt("cnt_timeout");
        reset_dut();
        nop_cycle();

        chk("req_q_left", req_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);

        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
